// File: rtl/char_fetch.sv
// Text-mode character renderer: maps the raster position to a character cell, fetches the
// glyph code and its font row, and emits one pixel per clock five cycles after the sample.
module char_fetch #(
   parameter int COLS         = 80,
   parameter int ROWS         = 24,
   parameter int ADDR_BITS    = 11,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           hcount,
   input  logic [9:0]           vcount,
   input  logic                 active_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   output logic [ADDR_BITS-1:0] raddr,
   input  logic [7:0]           char_in,
   output logic [10:0]          font_addr,
   input  logic [7:0]           font_data,
   input  logic [6:0]           cursor_x,
   input  logic [4:0]           cursor_y,
   output logic                 pixel_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 active_out
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [6:0]           col;
   logic [4:0]           row;
   logic                 in_area;
   logic                 cur_hit;
   logic [ADDR_BITS-1:0] raddr_d, raddr_q;
   logic [10:0]          font_addr_d, font_addr_q;
   logic                 font_bit;
   logic                 pixel_d, pixel_q;

   logic [4:0]           hs_q, vs_q, act_q;
   logic [3:0]           area_q, cur_q;
   logic [3:0][2:0]      phase_q;
   logic [1:0][3:0]      line_q;
   logic [1:0]           rev_q;

   logic [CNT_W-1:0]     blink_cnt_d, blink_cnt_q;
   logic                 blink_on_d, blink_on_q;
   logic                 vs_prev_q;
   logic                 vs_rise;

   assign col = hcount[9:3];
   assign row = vcount[8:4];

   // Lines at 512 and beyond would alias back onto row 0, so treat them as outside the text area.
   assign in_area = !vcount[9] && (int'(col) < COLS) && (int'(row) < ROWS);
   assign cur_hit = (col == cursor_x) && (row == cursor_y) && blink_on_q;

   always_comb begin
      raddr_d = '0;
      if (in_area) begin
         raddr_d = ADDR_BITS'(int'(row) * COLS + int'(col));
      end
   end

   assign font_addr_d = {char_in[6:0], line_q[1]};
   assign font_bit    = font_data[~phase_q[3]];
   assign pixel_d     = act_q[3] & area_q[3] & (font_bit ^ rev_q[1] ^ cur_q[3]);

   assign vs_rise = vsync_in & ~vs_prev_q;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (vs_rise) begin
         if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Side-band data rides in shift registers whose taps line up with the fetch stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raddr_q     <= '0;
         font_addr_q <= '0;
         pixel_q     <= 1'b0;
         hs_q        <= '0;
         vs_q        <= '0;
         act_q       <= '0;
         area_q      <= '0;
         cur_q       <= '0;
         phase_q     <= '0;
         line_q      <= '0;
         rev_q       <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         vs_prev_q   <= 1'b0;
      end else begin
         raddr_q     <= raddr_d;
         font_addr_q <= font_addr_d;
         pixel_q     <= pixel_d;
         hs_q        <= {hs_q[3:0], hsync_in};
         vs_q        <= {vs_q[3:0], vsync_in};
         act_q       <= {act_q[3:0], active_in};
         area_q      <= {area_q[2:0], in_area};
         cur_q       <= {cur_q[2:0], cur_hit};
         phase_q     <= {phase_q[2:0], hcount[2:0]};
         line_q      <= {line_q[0], vcount[3:0]};
         rev_q       <= {rev_q[0], char_in[7]};
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         vs_prev_q   <= vsync_in;
      end
   end

   assign raddr      = raddr_q;
   assign font_addr  = font_addr_q;
   assign pixel_out  = pixel_q;
   assign hsync_out  = hs_q[4];
   assign vsync_out  = vs_q[4];
   assign active_out = act_q[4];

endmodule

// File: tb/tb_char_fetch.sv
// Bench for char_fetch: registered buffer/ROM models, a latency-aligned scoreboard and
// table-driven cell renders plus hand-written blink and reset sequences.
module tb_char_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  hcount = '0, vcount = '0;
   logic        active_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [10:0] raddr;
   logic [7:0]  char_in = '0;
   logic [10:0] font_addr;
   logic [7:0]  font_data = '0;
   logic [6:0]  cursor_x = 7'd127;
   logic [4:0]  cursor_y = 5'd31;
   logic        pixel_out, hsync_out, vsync_out, active_out;

   always #5 clk = ~clk;

   char_fetch #(.COLS(80), .ROWS(24), .ADDR_BITS(11), .BLINK_FRAMES(30)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
      .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .raddr(raddr), .char_in(char_in), .font_addr(font_addr), .font_data(font_data),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .pixel_out(pixel_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out)
   );

   logic [7:0] mem [0:2047];
   logic [7:0] rom [0:2047];

   always @(posedge clk) begin
      char_in   <= mem[raddr];
      font_data <= rom[font_addr];
   end

   typedef struct {
      logic px, hs, vs, act;
      int   cap;
   } exp_t;

   typedef struct {
      string      name;
      int         col, row, line;
      bit         act, cur;
      logic [7:0] chr, rrow, exp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [10:0] qa[$];
   logic [10:0] qf[$];
   exp_t        qp[$];
   int          edges_mdl;
   bit          blink_mdl;
   bit          vs_prev_mdl;
   logic [7:0]  got_px [8];
   vec_t        tbl [9];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void model(input int h, input int v, input bit act, input int cx,
                                 input int cy, input bit blink, output logic [10:0] ra,
                                 output logic [10:0] fa, output logic px);
      int         c, r, ph;
      bit         area, cur;
      logic [7:0] ch, bits;
      c    = h / 8;
      r    = v / 16;
      ph   = h % 8;
      area = (c < 80) && (r < 24);
      ra   = area ? 11'(r * 80 + c) : 11'd0;
      ch   = mem[ra];
      fa   = {ch[6:0], 4'(v % 16)};
      bits = rom[fa];
      cur  = (c == cx) && (r == cy) && blink;
      px   = act && area && (bits[7 - ph] ^ ch[7] ^ cur);
   endfunction

   task automatic drive(input int h, input int v, input bit act, input bit hs, input bit vs,
                        input int cx, input int cy, input int cap);
      logic [10:0] ra, fa;
      logic        px;
      exp_t        e;
      hcount    = 10'(h);
      vcount    = 10'(v);
      active_in = act;
      hsync_in  = hs;
      vsync_in  = vs;
      cursor_x  = 7'(cx);
      cursor_y  = 5'(cy);
      model(h, v, act, cx, cy, blink_mdl, ra, fa, px);
      qa.push_back(ra);
      qf.push_back(fa);
      e.px = px; e.hs = hs; e.vs = vs; e.act = act; e.cap = cap;
      qp.push_back(e);
      if (vs && !vs_prev_mdl) begin
         edges_mdl++;
         if (edges_mdl % 30 == 0) blink_mdl = ~blink_mdl;
      end
      vs_prev_mdl = vs;
      @(posedge clk);
      #1;
      if (qa.size() == 1) chk("raddr", int'(raddr), int'(qa.pop_front()));
      if (qf.size() == 3) chk("font_addr", int'(font_addr), int'(qf.pop_front()));
      if (qp.size() == 5) begin
         e = qp.pop_front();
         chk("pixel_out", int'(pixel_out), int'(e.px));
         chk("hsync_out", int'(hsync_out), int'(e.hs));
         chk("vsync_out", int'(vsync_out), int'(e.vs));
         chk("active_out", int'(active_out), int'(e.act));
         if (e.cap >= 0) got_px[e.cap] = pixel_out;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_raddr"}, int'(raddr), 0);
      chk({tag, "_font_addr"}, int'(font_addr), 0);
      chk({tag, "_pixel"}, int'(pixel_out), 0);
      chk({tag, "_hsync"}, int'(hsync_out), 0);
      chk({tag, "_vsync"}, int'(vsync_out), 0);
      chk({tag, "_active"}, int'(active_out), 0);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      chk_zero({tag, "_async"});
      @(posedge clk);
      #1;
      chk_zero({tag, "_held"});
      reset = 1'b0;
      qa.delete();
      qf.delete();
      qp.delete();
      edges_mdl   = 0;
      blink_mdl   = 1'b1;
      vs_prev_mdl = 1'b0;
   endtask

   task automatic render(input int col, input int row, input int line, input bit act,
                         input int cx, input int cy, output logic [7:0] seq);
      for (int i = 0; i < 8; i++) got_px[i] = 1'b0;
      for (int p = 0; p < 8; p++) drive(col * 8 + p, row * 16 + line, act, 0, 0, cx, cy, p);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 127, 31, -1);
      for (int i = 0; i < 8; i++) seq[7 - i] = got_px[i];
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 1, 127, 31, -1);
         drive(0, 0, 0, 0, 0, 127, 31, -1);
      end
   endtask

   initial begin
      logic [7:0] seq;
      int         cx, cy;

      tbl[0] = '{"plain_A",     0,  0,  0, 1, 0, 8'h41, 8'h80, 8'h80};
      tbl[1] = '{"reverse",     5,  2,  0, 1, 0, 8'hC1, 8'h80, 8'h7F};
      tbl[2] = '{"rev_cursor",  5,  2,  0, 1, 1, 8'hC1, 8'h80, 8'h80};
      tbl[3] = '{"cursor",     10,  3,  0, 1, 1, 8'h41, 8'h80, 8'h7F};
      tbl[4] = '{"last_cell",  79, 23,  3, 1, 0, 8'h05, 8'hA5, 8'hA5};
      tbl[5] = '{"inactive",   20,  5,  7, 0, 0, 8'hC1, 8'hFF, 8'h00};
      tbl[6] = '{"col_oob",    80,  0,  0, 1, 0, 8'h00, 8'h00, 8'h00};
      tbl[7] = '{"row_oob",     3, 24,  0, 1, 0, 8'h00, 8'h00, 8'h00};
      tbl[8] = '{"rev_line15",  1,  1, 15, 1, 0, 8'hFF, 8'h3C, 8'hC3};

      for (int i = 0; i < 2048; i++) begin
         mem[i] = 8'($urandom);
         rom[i] = 8'($urandom);
      end
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].col < 80 && tbl[i].row < 24) begin
            mem[tbl[i].row * 80 + tbl[i].col] = tbl[i].chr;
            rom[{tbl[i].chr[6:0], 4'(tbl[i].line)}] = tbl[i].rrow;
         end
      end

      do_reset("reset");

      for (int i = 0; i < 9; i++) begin
         cx = tbl[i].cur ? tbl[i].col : 127;
         cy = tbl[i].cur ? tbl[i].row : 31;
         render(tbl[i].col, tbl[i].row, tbl[i].line, tbl[i].act, cx, cy, seq);
         chk({"cell_", tbl[i].name}, int'(seq), int'(tbl[i].exp));
      end

      drive(632, 368, 1, 0, 0, 127, 31, -1);
      chk("raddr_max", int'(raddr), 1919);
      for (int h = 0; h < 640; h++) drive(h, 384, 1, 0, 0, 127, 31, -1);
      chk("raddr_row24", int'(raddr), 0);

      pulses(30);
      render(5, 2, 0, 1, 5, 2, seq);
      chk("blink_off_30", int'(seq), 8'h7F);
      pulses(30);
      render(5, 2, 0, 1, 5, 2, seq);
      chk("blink_on_60", int'(seq), 8'h80);
      for (int i = 0; i < 1000; i++) drive(0, 0, 0, 0, 1, 127, 31, -1);
      drive(0, 0, 0, 0, 0, 127, 31, -1);
      pulses(28);
      render(5, 2, 0, 1, 5, 2, seq);
      chk("vsync_held_one_edge", int'(seq), 8'h80);
      pulses(1);
      render(5, 2, 0, 1, 5, 2, seq);
      chk("blink_off_90", int'(seq), 8'h7F);

      drive(0, 0, 1, 1, 1, 127, 31, -1);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, 1, 127, 31, -1);
      chk("pre_reset_pixel", int'(pixel_out), 1);
      do_reset("midline_reset");

      for (int i = 0; i < 400; i++) begin
         drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               1'($urandom), 1'($urandom), 1'($urandom), 127, 31, -1);
      end
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 127, 31, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
